hub75_bcm_scan: RTL and testbench

- Downstream consumer of the 8-to-12-bit gamma stage.
- Scans a HUB75 LED panel using binary code modulation (BCM) over 12 bit-planes.
- Fetches gamma-corrected 12-bit RGB pixel pairs (top half and bottom half) from the framebuffer/gamma path.
- Shifts one bit-plane per pass onto the panel's serial data lines, latches it, and enables output for a time weighted by 2^plane.

---
 rtl/hub75_pkg.sv | 22 ++
 rtl/hub75_bcm_timer.sv | 34 +++
 rtl/hub75_bcm_scan.sv | 209 ++++++++++++++++++++
 tb/tb_hub75_bcm_scan.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hub75_pkg.sv
// Shared state encoding and timing helpers for the HUB75 bit-plane scanner.
// DEPTH here is the gamma output width the scanner is built around.
package hub75_pkg;
    localparam int DEPTH   = 12;
    localparam int PLANE_W = $clog2(DEPTH);
    localparam int TMR_W   = DEPTH + 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREFETCH,
        ST_SHIFT,
        ST_BLANK,
        ST_LATCH,
        ST_DISPLAY
    } state_t;

    // Output-enable time for a plane grows as a power of two.
    function automatic logic [TMR_W-1:0] disp_count(input logic [7:0] base_on,
                                                    input logic [PLANE_W-1:0] plane);
        return TMR_W'(base_on) << plane;
    endfunction
endpackage

// File: rtl/hub75_bcm_timer.sv
// Loadable down-counter; done is high during the last cycle of a loaded interval.
// Loading N makes done fire N cycles later; a load always wins over counting.
module hub75_bcm_timer
    import hub75_pkg::*;
#(
    parameter int W = TMR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == W'(1));
endmodule

// File: rtl/hub75_bcm_scan.sv
// HUB75 scanner: per row and bit-plane, fetch COLS pixel pairs, shift them out, blank, latch, show.
// Fetch data is used one cycle after rd_en; there is no backpressure, the framebuffer must keep up.
module hub75_bcm_scan #(
    parameter int COLS     = 64,
    parameter int ROW_BITS = 4,
    parameter int DEPTH    = 12,
    parameter int CLK_DIV  = 1,
    parameter int BASE_ON  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    output logic                    rd_en,
    output logic [ROW_BITS-1:0]     rd_row,
    output logic [$clog2(COLS)-1:0] rd_col,
    input  logic [3*DEPTH-1:0]      rd_top,
    input  logic [3*DEPTH-1:0]      rd_bot,
    output logic                    hub_r0,
    output logic                    hub_g0,
    output logic                    hub_b0,
    output logic                    hub_r1,
    output logic                    hub_g1,
    output logic                    hub_b1,
    output logic                    hub_sclk,
    output logic                    hub_lat,
    output logic                    hub_oe_n,
    output logic [ROW_BITS-1:0]     hub_addr,
    output logic                    frame_done
);
    import hub75_pkg::*;

    localparam int COL_W = $clog2(COLS);
    localparam int PL_W  = $clog2(DEPTH);
    localparam int CNT_W = DEPTH + 8;
    localparam logic [COL_W-1:0]    COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_BITS-1:0] ROW_LAST = '1;
    localparam logic [PL_W-1:0]     PL_LAST  = PL_W'(DEPTH - 1);

    state_t              state_q, state_d;
    logic [ROW_BITS-1:0] row_q, row_d, addr_q, addr_d;
    logic [PL_W-1:0]     plane_q, plane_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic                sclk_q, sclk_d, first_q, first_d, blank_q, blank_d;
    logic                done_q, done_d, rd_vld_q, rd_vld_d;
    logic [6*DEPTH-1:0]  cap_q, cap_d;
    logic [5:0]          cur_q, cur_d, slot_bits, line_bits;
    logic                tmr_load, tmr_done;
    logic [CNT_W-1:0]    tmr_val;

    function automatic logic [2:0] plane_bits(input logic [3*DEPTH-1:0] px,
                                              input logic [PL_W-1:0] p);
        logic [DEPTH-1:0] r, g, b;
        r = px[3*DEPTH-1:2*DEPTH];
        g = px[2*DEPTH-1:DEPTH];
        b = px[DEPTH-1:0];
        return {r[p], g[p], b[p]};
    endfunction

    hub75_bcm_timer #(.W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // Column 0 arrives in the very first shift cycle, so it bypasses the capture buffer.
    always_comb begin
        if (col_q == '0) begin
            slot_bits = {plane_bits(rd_top, plane_q), plane_bits(rd_bot, plane_q)};
        end else begin
            slot_bits = {plane_bits(cap_q[6*DEPTH-1:3*DEPTH], plane_q),
                         plane_bits(cap_q[3*DEPTH-1:0], plane_q)};
        end
    end

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        plane_d  = plane_q;
        col_d    = col_q;
        sclk_d   = sclk_q;
        first_d  = first_q;
        blank_d  = blank_q;
        addr_d   = addr_q;
        done_d   = 1'b0;
        cur_d    = cur_q;
        rd_vld_d = rd_en;
        cap_d    = rd_vld_q ? {rd_top, rd_bot} : cap_q;
        tmr_load = 1'b0;
        tmr_val  = CNT_W'(CLK_DIV);
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_PREFETCH;
                    row_d   = '0;
                    plane_d = '0;
                end
            end
            ST_PREFETCH: begin
                state_d  = ST_SHIFT;
                col_d    = '0;
                sclk_d   = 1'b0;
                first_d  = 1'b1;
                tmr_load = 1'b1;
            end
            ST_SHIFT: begin
                first_d = 1'b0;
                if (first_q) begin
                    cur_d = slot_bits;
                end
                if (tmr_done) begin
                    if (!sclk_q) begin
                        sclk_d   = 1'b1;
                        tmr_load = 1'b1;
                    end else if (col_q == COL_LAST) begin
                        state_d = ST_BLANK;
                        sclk_d  = 1'b0;
                    end else begin
                        sclk_d   = 1'b0;
                        col_d    = col_q + 1'b1;
                        first_d  = 1'b1;
                        tmr_load = 1'b1;
                    end
                end
            end
            ST_BLANK: begin
                blank_d = 1'b1;
                if (blank_q) begin
                    state_d = ST_LATCH;
                    blank_d = 1'b0;
                end else begin
                    addr_d = row_q;
                end
            end
            ST_LATCH: begin
                state_d  = ST_DISPLAY;
                tmr_load = 1'b1;
                tmr_val  = CNT_W'(disp_count(8'(BASE_ON), plane_q));
            end
            ST_DISPLAY: begin
                if (tmr_done) begin
                    if (plane_q == PL_LAST) begin
                        plane_d = '0;
                        if (row_q == ROW_LAST) begin
                            row_d  = '0;
                            done_d = 1'b1;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        plane_d = plane_q + 1'b1;
                    end
                    // en is only honoured at plane boundaries.
                    if (en) begin
                        state_d = ST_PREFETCH;
                    end else begin
                        state_d = ST_IDLE;
                        row_d   = '0;
                        plane_d = '0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            row_q    <= '0;
            plane_q  <= '0;
            col_q    <= '0;
            sclk_q   <= 1'b0;
            first_q  <= 1'b0;
            blank_q  <= 1'b0;
            addr_q   <= '0;
            done_q   <= 1'b0;
            cur_q    <= '0;
            rd_vld_q <= 1'b0;
            cap_q    <= '0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            plane_q  <= plane_d;
            col_q    <= col_d;
            sclk_q   <= sclk_d;
            first_q  <= first_d;
            blank_q  <= blank_d;
            addr_q   <= addr_d;
            done_q   <= done_d;
            cur_q    <= cur_d;
            rd_vld_q <= rd_vld_d;
            cap_q    <= cap_d;
        end
    end

    assign rd_en      = (state_q == ST_PREFETCH) ||
                        (state_q == ST_SHIFT && first_q && col_q != COL_LAST);
    assign rd_row     = row_q;
    assign rd_col     = (state_q == ST_SHIFT) ? col_q + 1'b1 : '0;
    assign line_bits  = (state_q == ST_SHIFT) ? (first_q ? slot_bits : cur_q) : '0;
    assign {hub_r0, hub_g0, hub_b0, hub_r1, hub_g1, hub_b1} = line_bits;
    assign hub_sclk   = (state_q == ST_SHIFT) && sclk_q;
    assign hub_lat    = (state_q == ST_LATCH);
    assign hub_oe_n   = (state_q != ST_DISPLAY);
    assign hub_addr   = addr_q;
    assign frame_done = done_q;
endmodule

// File: tb/tb_hub75_bcm_scan.sv
// Bench for hub75_bcm_scan with 4 row pairs and BASE_ON=1 so a full frame stays short.
// A negedge monitor condenses each plane into a record that the directed tests compare.
module tb_hub75_bcm_scan;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic        rd_en;
    logic [1:0]  rd_row;
    logic [5:0]  rd_col;
    logic [35:0] rd_top = '0;
    logic [35:0] rd_bot = '0;
    logic        hub_r0, hub_g0, hub_b0, hub_r1, hub_g1, hub_b1;
    logic        hub_sclk, hub_lat, hub_oe_n, frame_done;
    logic [1:0]  hub_addr;

    hub75_bcm_scan #(
        .COLS(64), .ROW_BITS(2), .DEPTH(12), .CLK_DIV(1), .BASE_ON(1)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col),
        .rd_top(rd_top), .rd_bot(rd_bot),
        .hub_r0(hub_r0), .hub_g0(hub_g0), .hub_b0(hub_b0),
        .hub_r1(hub_r1), .hub_g1(hub_g1), .hub_b1(hub_b1),
        .hub_sclk(hub_sclk), .hub_lat(hub_lat), .hub_oe_n(hub_oe_n),
        .hub_addr(hub_addr), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int mode = 0;

    // mode 0: top r=001, bottom b=800.  mode 1: top g=col, bottom g=63-col.
    function automatic logic [71:0] pix(input int m, input logic [5:0] c);
        logic [11:0] cv, cr;
        cv = {6'd0, c};
        cr = {6'd0, 6'd63 - c};
        if (m == 0) return {12'h001, 12'h000, 12'h000, 12'h000, 12'h000, 12'h800};
        return {12'h000, cv, 12'h000, 12'h000, cr, 12'h000};
    endfunction

    always @(posedge clk) begin
        if (rd_en) {rd_top, rd_bot} <= pix(mode, rd_col);
    end

    typedef struct {
        logic [63:0] r0, g0, b0, r1, g1, b1;
        logic [63:0] col_mask;
        int edges, oe_w, lat_cnt, gap, col_cnt, dup, row_seen, addr, period, fd;
    } rec_t;

    rec_t recs[$];
    rec_t cur;
    int   fd_cnt = 0, rd_total = 0, viol = 0, cyc = 0, gap = 0;
    logic prev_oe = 1'b1, prev_sclk = 1'b0;
    logic [1:0] prev_addr = '0;

    always @(negedge clk) begin
        if (rst) begin
            cur = '{default: '0};
            prev_oe = 1'b1; prev_sclk = 1'b0; prev_addr = '0;
            cyc = 0; gap = 0; fd_cnt = 0;
        end else begin
            int e;
            cyc++;
            if (frame_done) fd_cnt++;
            if (hub_oe_n && !prev_oe) begin
                cur.period = cyc - 1;
                cur.fd = fd_cnt;
                recs.push_back(cur);
                cur = '{default: '0};
                cyc = 1;
            end
            if (!hub_oe_n && (hub_lat || hub_addr != prev_addr)) viol++;
            if (hub_sclk) gap = 0;
            else if (hub_oe_n && !hub_lat) gap++;
            if (hub_lat) begin
                cur.lat_cnt++;
                cur.gap = gap;
                cur.addr = int'(hub_addr);
            end
            if (!hub_oe_n) cur.oe_w++;
            e = cur.edges;
            if (hub_sclk && !prev_sclk && e < 64) begin
                cur.r0[e[5:0]] = hub_r0; cur.g0[e[5:0]] = hub_g0; cur.b0[e[5:0]] = hub_b0;
                cur.r1[e[5:0]] = hub_r1; cur.g1[e[5:0]] = hub_g1; cur.b1[e[5:0]] = hub_b1;
                cur.edges++;
            end
            if (rd_en) begin
                if (cur.col_mask[rd_col]) cur.dup++;
                cur.col_mask[rd_col] = 1'b1;
                cur.col_cnt++;
                cur.row_seen = int'(rd_row);
                rd_total++;
            end
            prev_oe = hub_oe_n; prev_sclk = hub_sclk; prev_addr = hub_addr;
        end
    end

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic get_rec(output rec_t r);
        int t = 0;
        while (recs.size() == 0 && t < 20000) begin
            @(negedge clk);
            t++;
        end
        if (recs.size() == 0) begin
            n_chk++;
            $display("FAIL plane_timeout: no plane completed within %0d cycles", t);
            r = '{default: '0};
        end else begin
            r = recs.pop_front();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        repeat (3) @(negedge clk);
        recs.delete();
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic idle_hold(input string nm);
        int bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (hub_oe_n !== 1'b1 || hub_lat !== 1'b0 || hub_sclk !== 1'b0 || rd_en !== 1'b0) bad++;
        end
        chk(nm, 64'(bad), 64'd0);
    endtask

    typedef struct {
        int mode;
        int plane;
        logic [63:0] r0, g0, b0, r1, g1, b1;
    } vec_t;

    vec_t tbl[4];
    rec_t r;

    initial begin
        tbl[0] = '{0, 0,  64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0};
        tbl[1] = '{0, 11, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
        tbl[2] = '{1, 0,  64'h0, 64'hAAAA_AAAA_AAAA_AAAA, 64'h0, 64'h0, 64'h5555_5555_5555_5555, 64'h0};
        tbl[3] = '{1, 5,  64'h0, 64'hFFFF_FFFF_0000_0000, 64'h0, 64'h0, 64'h0000_0000_FFFF_FFFF, 64'h0};

        // Reset values, then idle with en low.
        @(negedge clk);
        chk("rst_oe_n", 64'(hub_oe_n), 64'd1);
        chk("rst_sclk", 64'(hub_sclk), 64'd0);
        chk("rst_lat", 64'(hub_lat), 64'd0);
        chk("rst_rd_en", 64'(rd_en), 64'd0);
        chk("rst_addr", 64'(hub_addr), 64'd0);
        chk("rst_frame_done", 64'(frame_done), 64'd0);
        chk("rst_data", 64'({hub_r0, hub_g0, hub_b0, hub_r1, hub_g1, hub_b1}), 64'd0);
        do_reset();
        idle_hold("idle_en_low");

        // Shifted data per plane from the vector table.
        for (int i = 0; i < 4; i++) begin
            do_reset();
            mode = tbl[i].mode;
            en = 1'b1;
            for (int p = 0; p <= tbl[i].plane; p++) get_rec(r);
            chk($sformatf("v%0d_r0", i), r.r0, tbl[i].r0);
            chk($sformatf("v%0d_g0", i), r.g0, tbl[i].g0);
            chk($sformatf("v%0d_b0", i), r.b0, tbl[i].b0);
            chk($sformatf("v%0d_r1", i), r.r1, tbl[i].r1);
            chk($sformatf("v%0d_g1", i), r.g1, tbl[i].g1);
            chk($sformatf("v%0d_b1", i), r.b1, tbl[i].b1);
            chk($sformatf("v%0d_oe_w", i), 64'(r.oe_w), 64'(1) << tbl[i].plane);
        end

        // Full frame: plane structure, addresses, frame_done.
        do_reset();
        mode = 1;
        en = 1'b1;
        for (int i = 0; i < 49; i++) begin
            get_rec(r);
            chk($sformatf("fr%0d_addr", i), 64'(r.addr), 64'((i / 12) % 4));
            chk($sformatf("fr%0d_rd_row", i), 64'(r.row_seen), 64'((i / 12) % 4));
            if (i < 12) begin
                chk($sformatf("fr%0d_oe_w", i), 64'(r.oe_w), 64'(1) << i);
                chk($sformatf("fr%0d_lat", i), 64'(r.lat_cnt), 64'd1);
                chk($sformatf("fr%0d_blank", i), 64'(r.gap), 64'd2);
                chk($sformatf("fr%0d_edges", i), 64'(r.edges), 64'd64);
                chk($sformatf("fr%0d_cols", i), 64'(r.col_cnt), 64'd64);
                chk($sformatf("fr%0d_colmask", i), r.col_mask, 64'hFFFF_FFFF_FFFF_FFFF);
                chk($sformatf("fr%0d_dup", i), 64'(r.dup), 64'd0);
            end
            if (i == 1)  chk("fr1_period", 64'(r.period), 64'd134);
            if (i == 12) chk("fr12_period", 64'(r.period), 64'd133);
            if (i == 46) chk("fr46_fd", 64'(r.fd), 64'd0);
            if (i == 47) chk("fr47_fd", 64'(r.fd), 64'd1);
            if (i == 48) chk("fr48_fd", 64'(r.fd), 64'd1);
        end

        // en glitch inside a plane, then en drop during row 1 plane 3.
        do_reset();
        mode = 1;
        en = 1'b1;
        for (int i = 0; i < 13; i++) get_rec(r);
        repeat (10) @(negedge clk);
        en = 1'b0;
        repeat (4) @(negedge clk);
        en = 1'b1;
        get_rec(r);
        chk("glitch_oe_w", 64'(r.oe_w), 64'd2);
        chk("glitch_period", 64'(r.period), 64'd134);
        get_rec(r);
        chk("glitch_next_oe_w", 64'(r.oe_w), 64'd4);
        repeat (10) @(negedge clk);
        en = 1'b0;
        get_rec(r);
        chk("drop_oe_w", 64'(r.oe_w), 64'd8);
        chk("drop_addr", 64'(r.addr), 64'd1);
        begin
            int rd0;
            rd0 = rd_total;
            repeat (40) @(negedge clk);
            chk("drop_idle_fetch", 64'(rd_total - rd0), 64'd0);
        end
        chk("drop_idle_recs", 64'(recs.size()), 64'd0);
        chk("drop_idle_oe_n", 64'(hub_oe_n), 64'd1);
        chk("drop_no_frame_done", 64'(fd_cnt), 64'd0);
        en = 1'b1;
        get_rec(r);
        chk("restart_row", 64'(r.row_seen), 64'd0);
        chk("restart_plane0_oe_w", 64'(r.oe_w), 64'd1);
        chk("restart_addr", 64'(r.addr), 64'd0);

        // Asynchronous reset while the panel is lit.
        begin
            int t = 0;
            while (hub_oe_n !== 1'b0 && t < 2000) begin
                @(negedge clk);
                t++;
            end
            chk("display_reached", 64'(hub_oe_n), 64'd0);
        end
        #2 rst = 1'b1;
        #1;
        chk("async_oe_n", 64'(hub_oe_n), 64'd1);
        chk("async_lat", 64'(hub_lat), 64'd0);
        chk("async_rd_en", 64'(rd_en), 64'd0);
        chk("async_addr", 64'(hub_addr), 64'd0);
        en = 1'b0;
        repeat (2) @(negedge clk);
        recs.delete();
        rst = 1'b0;
        idle_hold("post_reset_idle");
        chk("oe_overlap_violations", 64'(viol), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
